// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between two byte producers.
// Producer A (primary result stream) and producer B (status/echo stream)
// each feed a private FIFO. A round-robin scheduler pops one byte at a time
// and emits a one-cycle strobe. Strobes are spaced by a full frame time
// because the transmitter has no ready handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | sample FIFOs; on any non-empty FIFO latch head byte and pop it
//   ISSUE | po_flag high for exactly one cycle
//   WAIT  | count FRAME_CYCLES cycles so the transmitter finishes the frame
module uart_tx_arbiter #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 9600,
    parameter int FRAME_BITS = 10,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] a_data,
    input  logic       a_flag,
    input  logic [7:0] b_data,
    input  logic       b_flag,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       po_src,
    output logic       busy,
    output logic       a_full,
    output logic       b_full,
    output logic [7:0] a_drop_cnt,
    output logic [7:0] b_drop_cnt
);

    localparam int FRAME_CYCLES = (CLK_FREQ / UART_BPS) * FRAME_BITS;
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = PTR_W + 1;
    localparam int WAIT_W       = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Index 0 is requester A, index 1 is requester B.
    logic [1:0]       w_in_flag;
    logic [1:0][7:0]  w_in_data;
    logic [1:0]       w_full;
    logic [1:0]       w_nonempty;
    logic [1:0]       w_pop;
    logic [1:0][7:0]  w_head;
    logic [1:0][7:0]  w_drop;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_last_src;
    logic [7:0]        r_po_data;
    logic              r_po_flag;
    logic              r_po_src;
    logic              r_busy;

    logic              w_grant;
    logic              w_grant_src;

    assign w_in_flag = {b_flag, a_flag};
    assign w_in_data = {b_data, a_data};

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        logic [7:0]       r_mem [FIFO_DEPTH];
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [CNT_W-1:0] r_count;
        logic [7:0]       r_drop;
        logic             w_push;

        // Fullness uses the registered count, so a same-cycle pop never
        // makes room for a write into a full FIFO.
        assign w_full[g]     = (r_count == FULL_CNT);
        assign w_nonempty[g] = (r_count != '0);
        assign w_push        = w_in_flag[g] && !w_full[g];
        assign w_head[g]     = r_mem[r_rd_ptr];
        assign w_drop[g]     = r_drop;

        // Byte storage; contents are don't-care until written.
        always_ff @(posedge sys_clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_in_data[g];
            end
        end

        // Pointers, occupancy and saturating drop counter.
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_drop   <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[g]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop[g]) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop[g]) begin
                    r_count <= r_count - 1'b1;
                end
                if (w_in_flag[g] && w_full[g] && (r_drop != 8'hFF)) begin
                    r_drop <= r_drop + 1'b1;
                end
            end
        end
    end

    // Round-robin grant, evaluated only while IDLE; ties go to the source
    // that did not win last time.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_src = 1'b0;
        if (r_state == IDLE) begin
            if (w_nonempty[0] && w_nonempty[1]) begin
                w_grant     = 1'b1;
                w_grant_src = ~r_last_src;
            end else if (w_nonempty[0]) begin
                w_grant     = 1'b1;
                w_grant_src = 1'b0;
            end else if (w_nonempty[1]) begin
                w_grant     = 1'b1;
                w_grant_src = 1'b1;
            end
        end
    end

    assign w_pop[0] = w_grant && !w_grant_src;
    assign w_pop[1] = w_grant &&  w_grant_src;

    // Scheduler FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
            r_last_src <= 1'b1;
            r_po_data  <= '0;
            r_po_flag  <= 1'b0;
            r_po_src   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_po_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_po_data  <= w_head[w_grant_src];
                        r_po_src   <= w_grant_src;
                        r_last_src <= w_grant_src;
                        r_po_flag  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign po_data    = r_po_data;
    assign po_flag    = r_po_flag;
    assign po_src     = r_po_src;
    assign busy       = r_busy;
    assign a_full     = w_full[0];
    assign b_full     = w_full[1];
    assign a_drop_cnt = w_drop[0];
    assign b_drop_cnt = w_drop[1];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with FRAME_CYCLES = 100 and FIFO_DEPTH = 4.
module tb_uart_tx_arbiter;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] a_data;
    logic       a_flag;
    logic [7:0] b_data;
    logic       b_flag;
    logic [7:0] po_data;
    logic       po_flag;
    logic       po_src;
    logic       busy;
    logic       a_full;
    logic       b_full;
    logic [7:0] a_drop_cnt;
    logic [7:0] b_drop_cnt;

    uart_tx_arbiter #(
        .CLK_FREQ  (1000),
        .UART_BPS  (100),
        .FRAME_BITS(10),
        .FIFO_DEPTH(4)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .a_data    (a_data),
        .a_flag    (a_flag),
        .b_data    (b_data),
        .b_flag    (b_flag),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .po_src    (po_src),
        .busy      (busy),
        .a_full    (a_full),
        .b_full    (b_full),
        .a_drop_cnt(a_drop_cnt),
        .b_drop_cnt(b_drop_cnt)
    );

    typedef struct {
        logic       a_flag;
        logic [7:0] a_data;
        logic       b_flag;
        logic [7:0] b_data;
        logic       exp_a_full;
        logic       exp_b_full;
        logic [7:0] exp_a_drop;
        logic [7:0] exp_b_drop;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       src;
        int         cyc;
    } issue_t;

    typedef struct {
        logic [7:0] data;
        logic       src;
    } exp_issue_t;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    issue_t q_iss[$];

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Record every transmitter strobe mid-cycle.
    always @(negedge sys_clk) begin
        if (po_flag === 1'b1) begin
            q_iss.push_back('{data: po_data, src: po_src, cyc: cyc});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        a_flag  = 1'b0;
        b_flag  = 1'b0;
        repeat (2) tick();
        sys_rst = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        for (int i = 0; i < 400 && busy !== lvl; i++) tick();
        check(name, 32'(busy), 32'(lvl));
    endtask

    task automatic wait_issues(input int n, input string name);
        for (int i = 0; i < 2000 && q_iss.size() < n; i++) tick();
        check(name, 32'(q_iss.size()), 32'(n));
    endtask

    task automatic write_a(input logic [7:0] d);
        a_data = d;
        a_flag = 1'b1;
        tick();
        a_flag = 1'b0;
    endtask

    task automatic write_b(input logic [7:0] d);
        b_data = d;
        b_flag = 1'b1;
        tick();
        b_flag = 1'b0;
    endtask

    vec_t       tv[6];
    exp_issue_t ex2[4];
    int         bcnt;

    initial begin
        // Six A writes during WAIT into a depth-4 FIFO.
        tv[0] = '{1'b1, 8'h31, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[1] = '{1'b1, 8'h32, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[2] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'd0};
        tv[3] = '{1'b1, 8'h34, 1'b0, 8'h00, 1'b1, 1'b0, 8'd0, 8'd0};
        tv[4] = '{1'b1, 8'h35, 1'b0, 8'h00, 1'b1, 1'b0, 8'd1, 8'd0};
        tv[5] = '{1'b1, 8'h36, 1'b0, 8'h00, 1'b1, 1'b0, 8'd2, 8'd0};
        ex2[0] = '{8'h11, 1'b0};
        ex2[1] = '{8'hB1, 1'b1};
        ex2[2] = '{8'h22, 1'b0};
        ex2[3] = '{8'hB2, 1'b1};

        a_data = 8'h00;
        b_data = 8'h00;
        sys_rst = 1'b1;
        a_flag = 1'b0;
        b_flag = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_po_data", 32'(po_data), 32'h0);
        check("rst_po_flag", 32'(po_flag), 32'h0);
        check("rst_po_src",  32'(po_src),  32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        check("rst_a_full",  32'(a_full),  32'h0);
        check("rst_b_full",  32'(b_full),  32'h0);
        check("rst_a_drop",  32'(a_drop_cnt), 32'h0);
        check("rst_b_drop",  32'(b_drop_cnt), 32'h0);
        sys_rst = 1'b0;
        tick();

        // 1: single A byte, latency and busy length
        q_iss.delete();
        write_a(8'h5A);
        check("t1_flag_t1", 32'(po_flag), 32'h0);
        tick();
        check("t1_flag_t2", 32'(po_flag), 32'h1);
        check("t1_data",    32'(po_data), 32'h5A);
        check("t1_src",     32'(po_src),  32'h0);
        check("t1_busy_t2", 32'(busy),    32'h1);
        bcnt = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (busy) bcnt++;
            else break;
        end
        check("t1_busy_len", 32'(bcnt), 32'd101);
        check("t1_idle_flag", 32'(po_flag), 32'h0);
        check("t1_issue_cnt", 32'(q_iss.size()), 32'd1);

        // 2: round-robin order and pulse spacing
        do_reset();
        q_iss.delete();
        a_data = 8'h11; a_flag = 1'b1;
        b_data = 8'hB1; b_flag = 1'b1;
        tick();
        a_data = 8'h22;
        b_data = 8'hB2;
        tick();
        a_flag = 1'b0;
        b_flag = 1'b0;
        wait_issues(4, "t2_issue_cnt");
        for (int i = 0; i < 4; i++) begin
            if (i < q_iss.size()) begin
                check($sformatf("t2_data%0d", i), 32'(q_iss[i].data), 32'(ex2[i].data));
                check($sformatf("t2_src%0d", i),  32'(q_iss[i].src),  32'(ex2[i].src));
                if (i > 0) begin
                    check($sformatf("t2_gap%0d", i), 32'(q_iss[i].cyc - q_iss[i-1].cyc), 32'd102);
                end
            end
        end

        // 3: overflow of A while a frame is in WAIT
        do_reset();
        write_b(8'hC0);
        wait_busy(1'b1, "t3_busy");
        tick();
        q_iss.delete();
        for (int i = 0; i < 6; i++) begin
            a_flag = tv[i].a_flag;
            a_data = tv[i].a_data;
            b_flag = tv[i].b_flag;
            b_data = tv[i].b_data;
            tick();
            check($sformatf("t3_a_full%0d", i), 32'(a_full), 32'(tv[i].exp_a_full));
            check($sformatf("t3_b_full%0d", i), 32'(b_full), 32'(tv[i].exp_b_full));
            check($sformatf("t3_a_drop%0d", i), 32'(a_drop_cnt), 32'(tv[i].exp_a_drop));
            check($sformatf("t3_b_drop%0d", i), 32'(b_drop_cnt), 32'(tv[i].exp_b_drop));
        end
        a_flag = 1'b0;
        b_flag = 1'b0;
        check("t3_no_early", 32'(q_iss.size()), 32'd0);
        wait_issues(4, "t3_issue_cnt");
        for (int i = 0; i < 4; i++) begin
            if (i < q_iss.size()) begin
                check($sformatf("t3_data%0d", i), 32'(q_iss[i].data), 32'(tv[i].a_data));
                check($sformatf("t3_src%0d", i),  32'(q_iss[i].src),  32'h0);
            end
        end

        // 4: pop and write on a full FIFO in the same IDLE cycle
        do_reset();
        write_b(8'hC4);
        wait_busy(1'b1, "t4_busy");
        write_a(8'h41);
        write_a(8'h42);
        write_a(8'h43);
        write_a(8'h44);
        check("t4_full", 32'(a_full), 32'h1);
        wait_busy(1'b0, "t4_idle");
        q_iss.delete();
        write_a(8'h99);
        check("t4_drop",   32'(a_drop_cnt), 32'd1);
        check("t4_unfull", 32'(a_full), 32'h0);
        check("t4_flag",   32'(po_flag), 32'h1);
        check("t4_data",   32'(po_data), 32'h41);
        wait_issues(4, "t4_issue_cnt");
        repeat (250) tick();
        check("t4_no_extra", 32'(q_iss.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_iss.size()) begin
                check($sformatf("t4_data%0d", i), 32'(q_iss[i].data), 32'(8'h41 + i));
            end
        end

        // 5: drop counter saturation on B
        do_reset();
        write_a(8'h51);
        wait_busy(1'b1, "t5_busy");
        b_data = 8'hE0;
        b_flag = 1'b1;
        repeat (4) tick();
        check("t5_full", 32'(b_full), 32'h1);
        repeat (10) tick();
        check("t5_drop10", 32'(b_drop_cnt), 32'd10);
        repeat (290) tick();
        b_flag = 1'b0;
        check("t5_sat", 32'(b_drop_cnt), 32'd255);
        check("t5_a_drop", 32'(a_drop_cnt), 32'd0);

        // 6: reset in the middle of WAIT with both FIFOs loaded
        do_reset();
        write_a(8'h61);
        wait_busy(1'b1, "t6_busy");
        tick();
        write_b(8'h71);
        for (int i = 0; i < 6; i++) write_a(8'h62 + 8'(i));
        check("t6_pre_full", 32'(a_full), 32'h1);
        check("t6_pre_drop", 32'(a_drop_cnt), 32'd2);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        check("t6_flag",   32'(po_flag), 32'h0);
        check("t6_busy",   32'(busy), 32'h0);
        check("t6_a_full", 32'(a_full), 32'h0);
        check("t6_b_full", 32'(b_full), 32'h0);
        check("t6_a_drop", 32'(a_drop_cnt), 32'd0);
        check("t6_b_drop", 32'(b_drop_cnt), 32'd0);
        check("t6_data",   32'(po_data), 32'h0);
        q_iss.delete();
        repeat (300) tick();
        check("t6_silent", 32'(q_iss.size()), 32'd0);
        write_a(8'h77);
        tick();
        check("t6_new_flag", 32'(po_flag), 32'h1);
        check("t6_new_data", 32'(po_data), 32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte producers: A = Sobel result stream (primary), B = status/echo stream.
- Each requester has its own FIFO. A round-robin scheduler pops one byte at a time and emits a one-cycle pi_flag/pi_data strobe to the transmitter.
- Successive strobes are spaced so that the transmitter (no ready signal) always completes a frame before the next strobe.
- Sits between sobel_ctrl / status logic and uart_tx, in the clk_50M domain.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- UART_BPS, 9600, transmitter baud rate.
- FRAME_BITS, 10, bits per UART frame (start + 8 data + stop).
- FIFO_DEPTH, 16, entries per requester FIFO; must be a power of 2, ≥ 2.

Ports:
- sys_clk  in  1  system clock (clk_50M).
- sys_rst  in  1  synchronous reset, active-high.
- a_data  in  8  requester A byte.
- a_flag  in  1  one-cycle write strobe for a_data.
- b_data  in  8  requester B byte.
- b_flag  in  1  one-cycle write strobe for b_data.
- po_data  out  8  byte to uart_tx pi_data.
- po_flag  out  1  one-cycle strobe to uart_tx pi_flag.
- po_src  out  1  source of the current/last issued byte (0 = A, 1 = B).
- busy  out  1  high while in ISSUE or WAIT.
- a_full  out  1  FIFO A full.
- b_full  out  1  FIFO B full.
- a_drop_cnt  out  8  bytes dropped from A; saturates at 255.
- b_drop_cnt  out  8  bytes dropped from B; saturates at 255.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; state IDLE; last_src = 1, so A wins the first tie.
- Derived constant: FRAME_CYCLES = (CLK_FREQ / UART_BPS) * FRAME_BITS, using integer division.

FIFO write rules:
- x_flag high and count < FIFO_DEPTH → byte written at that edge.
- x_flag high and count == FIFO_DEPTH → byte discarded; x_drop_cnt increments unless already 255.
- Full is judged on the registered count. A pop in the same cycle does not rescue a write when the FIFO is full.
- A write and a pop in the same cycle on a non-full FIFO are both performed; count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- x_full = (count == FIFO_DEPTH).

FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - Both FIFOs empty → stay in IDLE.
  - Only one FIFO non-empty → grant that one.
  - Both non-empty → grant the source ≠ last_src.
  - On a grant: latch po_data = head byte, set po_src and last_src, pop that FIFO, go to ISSUE.
- ISSUE (exactly 1 cycle): po_flag = 1, then go to WAIT with wait counter = 0.
- WAIT: counter increments each cycle. When the counter reaches FRAME_CYCLES-1, go to IDLE; that IDLE cycle samples the FIFOs.
- po_flag is high only in ISSUE.
- po_data and po_src hold their values until the next grant.

Timing:
- Latency: a flag at cycle t while IDLE with empty FIFOs → FIFO non-empty at t+1 → po_flag high at cycle t+2.
- Under continuous backlog, consecutive po_flag pulses are exactly FRAME_CYCLES+2 cycles apart (1 ISSUE + FRAME_CYCLES WAIT + 1 IDLE).
- A byte arriving during WAIT is queued and never issued early.

Reset mid-operation:
- sys_rst in any state returns to IDLE, empties both FIFOs, and clears the drop counters and outputs on the next edge.
- uart_tx shares the same reset, so no partial frame survives.

Test Plan (CLK_FREQ=1000, UART_BPS=100 → FRAME_CYCLES=100; FIFO_DEPTH=4):
1. Single A byte 0x5A at cycle t, system idle → po_flag high at t+2 with po_data=0x5A, po_src=0; busy high for 101 cycles; then idle.
2. A holds 0x11, 0x22 and B holds 0xB1, 0xB2, all written before the first grant → issue order 0x11(A), 0xB1(B), 0x22(A), 0xB2(B); po_flag pulses 102 cycles apart.
3. Six A bytes written on consecutive cycles while a frame is in WAIT → first 4 queued, a_full=1, a_drop_cnt=2; the queued bytes are later issued in write order.
4. Full FIFO A with a pop and an a_flag in the same IDLE cycle → the new byte is dropped (a_drop_cnt +1) and the count becomes 3.
5. 300 writes into a full FIFO B → b_drop_cnt saturates at 255.
6. sys_rst asserted mid-WAIT with both FIFOs holding data → next cycle: po_flag=0, busy=0, a_full=b_full=0, counters 0; no po_flag afterwards until a new write.
